// File: rtl/audio_pkg.sv
// audio_pkg: shared sample/frame sizes and stereo sample types for the audio output path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package audio_pkg;

    localparam int SLOT_BITS   = 32;
    localparam int SAMPLE_BITS = 16;
    localparam int FRAME_BITS  = 64;

    typedef logic signed [SAMPLE_BITS-1:0] sample_t;

    typedef struct packed {
        sample_t left;
        sample_t right;
    } stereo_t;

endpackage

// File: rtl/audio_i2s_out_if.sv
// audio_i2s_out_if: sample inputs, pacing strobe and I2S pins of the audio output stage.
// Latency: n/a (wiring only).
// Backpressure: none; the slave side owns the timebase and paces the master with next_sample.
interface audio_i2s_out_if;
    import audio_pkg::*;

    sample_t pcm_left;
    sample_t pcm_right;
    sample_t psg_left;
    sample_t psg_right;
    logic    mute;
    logic    next_sample;
    logic    i2s_lrck;
    logic    i2s_bck;
    logic    i2s_data;

    // Upstream sources / bench: drive samples, observe pacing strobe and pins
    modport master (
        output pcm_left, pcm_right, psg_left, psg_right, mute,
        input  next_sample, i2s_lrck, i2s_bck, i2s_data
    );

    // Output stage: consume samples, drive pacing strobe and pins
    modport slave (
        input  pcm_left, pcm_right, psg_left, psg_right, mute,
        output next_sample, i2s_lrck, i2s_bck, i2s_data
    );

endinterface

// File: rtl/audio_mix_sat.sv
// audio_mix_sat: combinational 16+16 signed mixer; AUDIO_MIX_SAT_EN selects saturation, else wraps.
// Latency: 0 clk (purely combinational).
// Backpressure: none.
module audio_mix_sat
    import audio_pkg::*;
(
    input  sample_t a,
    input  sample_t b,
    output sample_t y
);

    logic signed [SAMPLE_BITS:0] sum;

    // One guard bit is enough: two 16-bit signed values never overflow 17 bits
    assign sum = {a[SAMPLE_BITS-1], a} + {b[SAMPLE_BITS-1], b};

`ifdef AUDIO_MIX_SAT_EN
    // Overflow shows as guard bit disagreeing with the 16-bit sign; clamp toward the sum's true sign
    always_comb begin
        y = sum[SAMPLE_BITS-1:0];
        if (sum[SAMPLE_BITS] != sum[SAMPLE_BITS-1]) begin
            y = sum[SAMPLE_BITS] ? sample_t'(16'h8000) : sample_t'(16'h7FFF);
        end
    end
`else
    // Plain two's-complement wrap: keep the low 16 bits
    always_comb begin
        y = sum[SAMPLE_BITS-1:0];
    end
`endif

endmodule

// File: rtl/audio_i2s_out.sv
// audio_i2s_out: mixes PCM+PSG stereo, captures one frame per sample period, serializes as I2S (build option AUDIO_MIX_SAT_EN).
// Latency: inputs captured at cnt=FRAME_LEN-1; left MSB on i2s_data 2^(BCK_DIV_LOG2+1)+1 clk later.
// Backpressure: none; free-running timebase, next_sample paces the upstream sources once per frame.
module audio_i2s_out
    import audio_pkg::*;
#(
    parameter int BCK_DIV_LOG2 = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    audio_i2s_out_if.slave  bus
);

    localparam int CNT_W = BCK_DIV_LOG2 + 7;
    localparam int PH_W  = BCK_DIV_LOG2 + 1;
    localparam int BIT_W = $clog2(FRAME_BITS);

    // Slot boundaries in bit-index units; one-bit delay after each LRCK edge
    localparam logic [BIT_W-1:0] L_FIRST = BIT_W'(1);
    localparam logic [BIT_W-1:0] L_LAST  = BIT_W'(SAMPLE_BITS);
    localparam logic [BIT_W-1:0] R_FIRST = BIT_W'(SLOT_BITS + 1);
    localparam logic [BIT_W-1:0] R_LAST  = BIT_W'(SLOT_BITS + SAMPLE_BITS);

    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_nxt;
    logic [BIT_W-1:0]       bit_nxt;
    logic [PH_W-1:0]        ph_nxt;
    logic                   capture;
    logic                   shift_ph;
    logic                   in_left;
    logic                   in_right;

    sample_t                mix_l;
    sample_t                mix_r;
    stereo_t                mixed;

    logic [SAMPLE_BITS-1:0] sh_l;
    logic [SAMPLE_BITS-1:0] sh_r;

    logic                   next_sample_q;
    logic                   lrck_q;
    logic                   bck_q;
    logic                   data_q;

    // Frame length is a power of two, so the natural wrap of cnt+1 closes the frame
    assign cnt_nxt  = cnt + 1'b1;
    assign bit_nxt  = cnt_nxt[CNT_W-1 -: BIT_W];
    assign ph_nxt   = cnt_nxt[PH_W-1:0];
    assign capture  = &cnt;
    assign shift_ph = (ph_nxt == '0);
    assign in_left  = (bit_nxt >= L_FIRST) && (bit_nxt <= L_LAST);
    assign in_right = (bit_nxt >= R_FIRST) && (bit_nxt <= R_LAST);

    audio_mix_sat u_mix_l (
        .a (bus.pcm_left),
        .b (bus.psg_left),
        .y (mix_l)
    );

    audio_mix_sat u_mix_r (
        .a (bus.pcm_right),
        .b (bus.psg_right),
        .y (mix_r)
    );

    assign mixed = '{left: mix_l, right: mix_r};

    // Free-running frame timebase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

    // Load a fresh frame at the last count; otherwise shift on each falling BCK inside its slot.
    // Capture happens at bit index 0 of the next frame, so it never collides with a shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_l <= '0;
            sh_r <= '0;
        end else if (capture) begin
            sh_l <= bus.mute ? '0 : mixed.left;
            sh_r <= bus.mute ? '0 : mixed.right;
        end else if (shift_ph) begin
            if (in_left) begin
                sh_l <= sh_l << 1;
            end
            if (in_right) begin
                sh_r <= sh_r << 1;
            end
        end
    end

    // Output flops decode the next counter value so each pin lines up with the current cnt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            next_sample_q <= 1'b0;
            lrck_q        <= 1'b0;
            bck_q         <= 1'b0;
            data_q        <= 1'b0;
        end else begin
            next_sample_q <= (cnt_nxt == '0);
            lrck_q        <= bit_nxt[BIT_W-1];
            bck_q         <= ph_nxt[PH_W-1];
            if (shift_ph) begin
                data_q <= in_left  ? sh_l[SAMPLE_BITS-1] :
                          in_right ? sh_r[SAMPLE_BITS-1] : 1'b0;
            end
        end
    end

    assign bus.next_sample = next_sample_q;
    assign bus.i2s_lrck    = lrck_q;
    assign bus.i2s_bck     = bck_q;
    assign bus.i2s_data    = data_q;

endmodule

// File: tb/tb_audio_i2s_out.sv
// tb_audio_i2s_out: directed bench for the I2S output stage (default BCK_DIV_LOG2 = 2, 512-clk frame).
// Latency: expectations derived from a bench-side frame counter.
// Backpressure: n/a.
module tb_audio_i2s_out;
    import audio_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    audio_i2s_out_if bus();

    audio_i2s_out #(.BCK_DIV_LOG2(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    int cnt_m = 0;

    logic [63:0] bits;
    int          fmt_err;
    int          ns_first, ns_gap1, ns_gap2, ns_cnt;
    int          bck0, bck1, lr0, lr1, ones;

    task automatic check_b(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_i(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_v(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_frame(input logic [15:0] l, input logic [15:0] r);
        logic [63:0] e;
        e        = '0;
        e[62:47] = l;   // b = 1..16
        e[30:15] = r;   // b = 33..48
        return e;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
        cnt_m = (cnt_m + 1) % 512;
    endtask

    task automatic skip_frame;
        repeat (512) tick();
    endtask

    // Walk one whole frame from cnt = 0, sampling data at each BCK rise and checking framing
    task automatic decode_frame(input int chg_at, input logic [15:0] chg_val, input bit mute_cap,
                                output logic [63:0] f_bits, output int f_err);
        logic dat_hold;
        f_bits   = '0;
        f_err    = 0;
        dat_hold = 1'b0;
        for (int i = 0; i < 512; i++) begin
            int ph;
            int b;
            ph = i % 8;
            b  = i / 8;
            if (bus.i2s_lrck !== (b >= 32)) f_err++;
            if (bus.i2s_bck !== (ph >= 4)) f_err++;
            if (bus.next_sample !== (i == 0)) f_err++;
            if (ph == 4) begin
                f_bits[63-b] = bus.i2s_data;
                dat_hold     = bus.i2s_data;
            end else if (ph > 4 && bus.i2s_data !== dat_hold) begin
                f_err++;
            end
            if (i == chg_at) bus.pcm_left = chg_val;
            if (i == 511 && mute_cap) bus.mute = 1'b1;
            tick();
            bus.mute = 1'b0;
        end
    endtask

    // Run n clk edges after reset release, recording strobe and clock edge positions
    task automatic run_timebase(input int n, output int t_first, output int t_gap1, output int t_gap2,
                                output int t_cnt, output int t_bck0, output int t_bck1,
                                output int t_lr0, output int t_lr1, output int t_ones);
        int   ns_k[3];
        int   nb;
        int   nl;
        logic pb;
        logic pl;
        ns_k   = '{-1, -1, -1};
        t_cnt  = 0;
        nb     = 0;
        nl     = 0;
        t_bck0 = -1; t_bck1 = -1; t_lr0 = -1; t_lr1 = -1;
        t_ones = 0;
        for (int k = 0; k < n; k++) begin
            pb = bus.i2s_bck;
            pl = bus.i2s_lrck;
            tick();
            if (bus.next_sample === 1'b1) begin
                if (t_cnt < 3) ns_k[t_cnt] = k;
                t_cnt++;
            end
            if (bus.i2s_bck === 1'b1 && pb === 1'b0) begin
                if (nb == 0) t_bck0 = k;
                if (nb == 1) t_bck1 = k;
                nb++;
            end
            if (bus.i2s_lrck === 1'b1 && pl === 1'b0) begin
                if (nl == 0) t_lr0 = k;
                if (nl == 1) t_lr1 = k;
                nl++;
            end
            if (k <= 511 && bus.i2s_data !== 1'b0) t_ones++;
        end
        t_first = ns_k[0];
        t_gap1  = ns_k[1] - ns_k[0];
        t_gap2  = ns_k[2] - ns_k[1];
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.pcm_left   = '0;
        bus.pcm_right  = '0;
        bus.psg_left   = '0;
        bus.psg_right  = '0;
        bus.mute       = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_b("rst_next_sample", bus.next_sample, 1'b0);
        check_b("rst_lrck", bus.i2s_lrck, 1'b0);
        check_b("rst_bck", bus.i2s_bck, 1'b0);
        check_b("rst_data", bus.i2s_data, 1'b0);

        // Timebase over 3 frames; samples for serialization are presented from the start
        bus.pcm_left  = 16'h1234;
        bus.pcm_right = 16'hA5C3;
        rst_n = 1'b1;
        cnt_m = 0;
        run_timebase(1536, ns_first, ns_gap1, ns_gap2, ns_cnt, bck0, bck1, lr0, lr1, ones);
        check_i("ns_first", ns_first, 511);
        check_i("ns_gap1", ns_gap1, 512);
        check_i("ns_gap2", ns_gap2, 512);
        check_i("ns_count", ns_cnt, 3);
        check_i("bck_first_rise", bck0, 3);
        check_i("bck_period", bck1 - bck0, 8);
        check_i("lrck_first_rise", lr0, 255);
        check_i("lrck_period", lr1 - lr0, 512);
        check_i("first_frame_zero", ones, 0);

        // Serialization
        decode_frame(-1, 16'h0, 1'b0, bits, fmt_err);
        check_v("ser_frame", bits, exp_frame(16'h1234, 16'hA5C3));
        check_i("ser_format", fmt_err, 0);

        // Saturation / wrap
        bus.pcm_left  = 16'h7000;
        bus.psg_left  = 16'h2000;
        bus.pcm_right = 16'h8000;
        bus.psg_right = 16'hFFFF;
        skip_frame();
        decode_frame(-1, 16'h0, 1'b0, bits, fmt_err);
`ifdef AUDIO_MIX_SAT_EN
        check_v("sat_frame", bits, exp_frame(16'h7FFF, 16'h8000));
`else
        check_v("wrap_frame", bits, exp_frame(16'h9000, 16'h7FFF));
`endif
        check_i("sat_format", fmt_err, 0);

        // Capture window: mid-frame change lands one frame later
        bus.pcm_left  = 16'h0100;
        bus.pcm_right = 16'h0000;
        bus.psg_left  = 16'h0000;
        bus.psg_right = 16'h0000;
        skip_frame();
        decode_frame(300, 16'h0200, 1'b0, bits, fmt_err);
        check_v("win_current", bits, exp_frame(16'h0100, 16'h0000));
        check_i("win_format", fmt_err, 0);

        // Mute only during the capture cycle; pcm = 4000 presented this frame
        bus.pcm_right = 16'h4000;
        decode_frame(300, 16'h4000, 1'b1, bits, fmt_err);
        check_v("win_next", bits, exp_frame(16'h0200, 16'h0000));
        decode_frame(-1, 16'h0, 1'b0, bits, fmt_err);
        check_v("mute_frame", bits, 64'h0);
        check_i("mute_format", fmt_err, 0);
        decode_frame(-1, 16'h0, 1'b0, bits, fmt_err);
        check_v("unmute_frame", bits, exp_frame(16'h4000, 16'h4000));

        // Reset mid-frame at cnt = 200
        repeat (200) tick();
        check_i("pre_reset_cnt", cnt_m, 200);
        rst_n = 1'b0;
        #1;
        check_b("midrst_next_sample", bus.next_sample, 1'b0);
        check_b("midrst_lrck", bus.i2s_lrck, 1'b0);
        check_b("midrst_bck", bus.i2s_bck, 1'b0);
        check_b("midrst_data", bus.i2s_data, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cnt_m = 0;
        run_timebase(1024, ns_first, ns_gap1, ns_gap2, ns_cnt, bck0, bck1, lr0, lr1, ones);
        check_i("rerst_ns_first", ns_first, 511);
        check_i("rerst_ns_gap1", ns_gap1, 512);
        check_i("rerst_bck_first", bck0, 3);
        check_i("rerst_lrck_first", lr0, 255);
        check_i("rerst_first_frame_zero", ones, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
